// File: rtl/br_update_queue.sv
// Branch-update training queue: buffers resolved conditional branches and
// drains one saturated pattern-history counter update per cycle, with a
// last-write bypass for back-to-back updates to the same index.
module br_update_queue #(
  parameter int ENQ_WIDTH  = 2,
  parameter int DEPTH      = 8,
  parameter int INDEX_BITS = 10,
  parameter int CTR_BITS   = 2,
  parameter int DROP_BITS  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ENQ_WIDTH-1:0]             enq_valid,
  input  logic [ENQ_WIDTH*INDEX_BITS-1:0]  enq_index,
  input  logic [ENQ_WIDTH-1:0]             enq_taken,
  input  logic [ENQ_WIDTH*CTR_BITS-1:0]    enq_prev_ctr,
  output logic                             enq_ready,
  output logic                             upd_valid,
  output logic [INDEX_BITS-1:0]            upd_index,
  output logic [CTR_BITS-1:0]              upd_ctr,
  input  logic                             upd_ready,
  output logic [$clog2(DEPTH):0]           occupancy,
  output logic [DROP_BITS-1:0]             drop_count
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int OCC_BITS = PTR_BITS + 1;
  localparam logic [CTR_BITS-1:0] CTR_MAX   = '1;
  localparam logic [OCC_BITS-1:0] DEPTH_OCC = OCC_BITS'(DEPTH);
  localparam logic [OCC_BITS-1:0] ENQ_OCC   = OCC_BITS'(ENQ_WIDTH);

  // Queue storage (not reset; validity comes from the pointers)
  logic [INDEX_BITS-1:0] ent_index_q [DEPTH];
  logic [INDEX_BITS-1:0] ent_index_d [DEPTH];
  logic                  ent_taken_q [DEPTH];
  logic                  ent_taken_d [DEPTH];
  logic [CTR_BITS-1:0]   ent_ctr_q   [DEPTH];
  logic [CTR_BITS-1:0]   ent_ctr_d   [DEPTH];

  logic [PTR_BITS-1:0]   head_q, head_d;
  logic [PTR_BITS-1:0]   tail_q, tail_d;
  logic [OCC_BITS-1:0]   occ_q, occ_d;
  logic [DROP_BITS-1:0]  drop_q, drop_d;
  logic                  byp_valid_q, byp_valid_d;
  logic [INDEX_BITS-1:0] byp_index_q, byp_index_d;
  logic [CTR_BITS-1:0]   byp_ctr_q, byp_ctr_d;

  logic [OCC_BITS-1:0]   enq_cnt;
  logic [PTR_BITS-1:0]   lane_off [ENQ_WIDTH];
  logic [DROP_BITS:0]    drop_sum;
  logic                  pop;
  logic                  head_taken;
  logic [CTR_BITS-1:0]   head_prev;
  logic [CTR_BITS-1:0]   base_ctr;

  // Popcount of valid lanes and each lane's compacted slot offset
  always_comb begin
    enq_cnt = '0;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      lane_off[i] = enq_cnt[PTR_BITS-1:0];
      if (enq_valid[i]) enq_cnt = enq_cnt + OCC_BITS'(1);
    end
  end

  // Head view, bypass selection and saturating counter update
  always_comb begin
    enq_ready  = (DEPTH_OCC - occ_q) >= ENQ_OCC;
    upd_valid  = occ_q != '0;
    upd_index  = ent_index_q[head_q];
    head_taken = ent_taken_q[head_q];
    head_prev  = ent_ctr_q[head_q];
    base_ctr   = (byp_valid_q && (byp_index_q == upd_index)) ? byp_ctr_q : head_prev;
    if (head_taken) upd_ctr = (base_ctr == CTR_MAX) ? CTR_MAX : base_ctr + CTR_BITS'(1);
    else            upd_ctr = (base_ctr == '0) ? '0 : base_ctr - CTR_BITS'(1);
    pop        = upd_valid && upd_ready;
    occupancy  = occ_q;
    drop_count = drop_q;
  end

  // Pointer, occupancy, drop counter and bypass next-state
  always_comb begin
    head_d      = pop ? head_q + PTR_BITS'(1) : head_q;
    tail_d      = enq_ready ? tail_q + enq_cnt[PTR_BITS-1:0] : tail_q;
    occ_d       = occ_q + (enq_ready ? enq_cnt : '0) - (pop ? OCC_BITS'(1) : '0);
    drop_sum    = {1'b0, drop_q} + (DROP_BITS+1)'(enq_cnt);
    drop_d      = drop_q;
    if (!enq_ready && (enq_cnt != '0))
      drop_d = drop_sum[DROP_BITS] ? '1 : drop_sum[DROP_BITS-1:0];
    byp_valid_d = byp_valid_q;
    byp_index_d = byp_index_q;
    byp_ctr_d   = byp_ctr_q;
    if (pop) begin
      byp_valid_d = 1'b1;
      byp_index_d = upd_index;
      byp_ctr_d   = upd_ctr;
    end
  end

  // Compacted writes of accepted lanes into consecutive tail slots
  always_comb begin
    ent_index_d = ent_index_q;
    ent_taken_d = ent_taken_q;
    ent_ctr_d   = ent_ctr_q;
    if (enq_ready) begin
      for (int i = 0; i < ENQ_WIDTH; i++) begin
        if (enq_valid[i]) begin
          ent_index_d[tail_q + lane_off[i]] = enq_index[i*INDEX_BITS +: INDEX_BITS];
          ent_taken_d[tail_q + lane_off[i]] = enq_taken[i];
          ent_ctr_d[tail_q + lane_off[i]]   = enq_prev_ctr[i*CTR_BITS +: CTR_BITS];
        end
      end
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      drop_q      <= '0;
      byp_valid_q <= 1'b0;
      byp_index_q <= '0;
      byp_ctr_q   <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      occ_q       <= occ_d;
      drop_q      <= drop_d;
      byp_valid_q <= byp_valid_d;
      byp_index_q <= byp_index_d;
      byp_ctr_q   <= byp_ctr_d;
    end
  end

  // Entry storage registers
  always_ff @(posedge clk) begin
    ent_index_q <= ent_index_d;
    ent_taken_q <= ent_taken_d;
    ent_ctr_q   <= ent_ctr_d;
  end

endmodule

// File: tb/tb_br_update_queue.sv
// Directed bench for br_update_queue: vector table plus hand sequences for
// full/drop and reset-while-draining.
module tb_br_update_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  enq_valid;
  logic [19:0] enq_index;
  logic [1:0]  enq_taken;
  logic [3:0]  enq_prev_ctr;
  logic        enq_ready;
  logic        upd_valid;
  logic [9:0]  upd_index;
  logic [1:0]  upd_ctr;
  logic        upd_ready;
  logic [3:0]  occupancy;
  logic [15:0] drop_count;

  int tests = 0;
  int fails = 0;

  br_update_queue dut (
    .clk          (clk),
    .rst          (rst),
    .enq_valid    (enq_valid),
    .enq_index    (enq_index),
    .enq_taken    (enq_taken),
    .enq_prev_ctr (enq_prev_ctr),
    .enq_ready    (enq_ready),
    .upd_valid    (upd_valid),
    .upd_index    (upd_index),
    .upd_ctr      (upd_ctr),
    .upd_ready    (upd_ready),
    .occupancy    (occupancy),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  ev;
    logic [9:0]  i0, i1;
    logic [1:0]  tk;
    logic [1:0]  p0, p1;
    logic        ur;
    logic        xv;
    logic [9:0]  xidx;
    logic [1:0]  xctr;
    logic        xer;
    logic [3:0]  xocc;
    logic [15:0] xdrop;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] ev, input logic [9:0] i0, input logic [9:0] i1,
                     input logic [1:0] tk, input logic [1:0] p0, input logic [1:0] p1, input logic ur,
                     input logic xv, input logic [9:0] xidx, input logic [1:0] xctr, input logic xer,
                     input logic [3:0] xocc, input logic [15:0] xdrop);
    vec_t v;
    v.rst = r; v.ev = ev; v.i0 = i0; v.i1 = i1; v.tk = tk; v.p0 = p0; v.p1 = p1; v.ur = ur;
    v.xv = xv; v.xidx = xidx; v.xctr = xctr; v.xer = xer; v.xocc = xocc; v.xdrop = xdrop;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic [1:0] ev, input logic [9:0] i0, input logic [9:0] i1,
                        input logic [1:0] tk, input logic [1:0] p0, input logic [1:0] p1, input logic ur);
    rst          = r;
    enq_valid    = ev;
    enq_index    = {i1, i0};
    enq_taken    = tk;
    enq_prev_ctr = {p1, p0};
    upd_ready    = ur;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_in(1'b1, 2'b00, 10'h0, 10'h0, 2'b00, 2'd0, 2'd0, 1'b0);

    //  rst ev     i0      i1      tk     p0 p1 ur   xv xidx    xctr er occ drop
    add(1, 2'b00, 10'h000, 10'h000, 2'b00, 0, 0, 0,  0, 10'h000, 0, 1, 0, 0);
    add(0, 2'b01, 10'h005, 10'h000, 2'b01, 1, 0, 1,  1, 10'h005, 2, 1, 1, 0);
    add(0, 2'b00, 10'h000, 10'h000, 2'b00, 0, 0, 1,  0, 10'h000, 0, 1, 0, 0);
    add(0, 2'b01, 10'h007, 10'h000, 2'b01, 3, 0, 1,  1, 10'h007, 3, 1, 1, 0);
    add(0, 2'b01, 10'h008, 10'h000, 2'b00, 0, 0, 1,  1, 10'h008, 0, 1, 1, 0);
    add(0, 2'b00, 10'h000, 10'h000, 2'b00, 0, 0, 1,  0, 10'h000, 0, 1, 0, 0);
    add(0, 2'b11, 10'h010, 10'h010, 2'b11, 1, 1, 1,  1, 10'h010, 2, 1, 2, 0);
    add(0, 2'b11, 10'h010, 10'h010, 2'b11, 1, 1, 1,  1, 10'h010, 3, 1, 3, 0);
    add(0, 2'b00, 10'h000, 10'h000, 2'b00, 0, 0, 1,  1, 10'h010, 3, 1, 2, 0);
    add(0, 2'b00, 10'h000, 10'h000, 2'b00, 0, 0, 1,  1, 10'h010, 3, 1, 1, 0);
    add(0, 2'b00, 10'h000, 10'h000, 2'b00, 0, 0, 1,  0, 10'h000, 0, 1, 0, 0);
    add(0, 2'b11, 10'h011, 10'h010, 2'b11, 1, 1, 1,  1, 10'h011, 2, 1, 2, 0);
    add(0, 2'b00, 10'h000, 10'h000, 2'b00, 0, 0, 0,  1, 10'h011, 2, 1, 2, 0);
    add(0, 2'b00, 10'h000, 10'h000, 2'b00, 0, 0, 1,  1, 10'h010, 2, 1, 1, 0);
    add(0, 2'b00, 10'h000, 10'h000, 2'b00, 0, 0, 1,  0, 10'h000, 0, 1, 0, 0);
    add(0, 2'b10, 10'h3ff, 10'h022, 2'b10, 3, 2, 1,  1, 10'h022, 3, 1, 1, 0);
    add(0, 2'b11, 10'h030, 10'h031, 2'b00, 2, 1, 0,  1, 10'h022, 3, 1, 3, 0);
    add(0, 2'b00, 10'h000, 10'h000, 2'b00, 0, 0, 1,  1, 10'h030, 1, 1, 2, 0);
    add(0, 2'b00, 10'h000, 10'h000, 2'b00, 0, 0, 1,  1, 10'h031, 0, 1, 1, 0);
    add(0, 2'b00, 10'h000, 10'h000, 2'b00, 0, 0, 1,  0, 10'h000, 0, 1, 0, 0);

    for (int k = 0; k < vecs.size(); k++) begin
      set_in(vecs[k].rst, vecs[k].ev, vecs[k].i0, vecs[k].i1, vecs[k].tk,
             vecs[k].p0, vecs[k].p1, vecs[k].ur);
      tick();
      check($sformatf("v%0d.upd_valid", k), 32'(upd_valid), 32'(vecs[k].xv));
      check($sformatf("v%0d.enq_ready", k), 32'(enq_ready), 32'(vecs[k].xer));
      check($sformatf("v%0d.occupancy", k), 32'(occupancy), 32'(vecs[k].xocc));
      check($sformatf("v%0d.drop_count", k), 32'(drop_count), 32'(vecs[k].xdrop));
      if (vecs[k].xv) begin
        check($sformatf("v%0d.upd_index", k), 32'(upd_index), 32'(vecs[k].xidx));
        check($sformatf("v%0d.upd_ctr", k), 32'(upd_ctr), 32'(vecs[k].xctr));
      end
    end

    // Fill under stall: fifth group must be dropped whole
    for (int k = 0; k < 5; k++) begin
      set_in(1'b0, 2'b11, 10'(10'h040 + 2*k), 10'(10'h041 + 2*k), 2'b11, 2'd0, 2'd0, 1'b0);
      tick();
      check($sformatf("fill%0d.occupancy", k), 32'(occupancy), (k < 4) ? 32'(2*k + 2) : 32'd8);
      check($sformatf("fill%0d.enq_ready", k), 32'(enq_ready), (k < 3) ? 32'd1 : 32'd0);
      check($sformatf("fill%0d.drop_count", k), 32'(drop_count), (k == 4) ? 32'd2 : 32'd0);
      check($sformatf("fill%0d.upd_index", k), 32'(upd_index), 32'h040);
    end

    // Drain in order; enq_ready returns once occupancy <= 6
    for (int k = 0; k < 8; k++) begin
      set_in(1'b0, 2'b00, 10'h0, 10'h0, 2'b00, 2'd0, 2'd0, 1'b1);
      check($sformatf("drain%0d.upd_valid", k), 32'(upd_valid), 32'd1);
      check($sformatf("drain%0d.upd_index", k), 32'(upd_index), 32'(10'h040 + k));
      check($sformatf("drain%0d.upd_ctr", k), 32'(upd_ctr), 32'd1);
      tick();
      check($sformatf("drain%0d.occupancy", k), 32'(occupancy), 32'(7 - k));
      check($sformatf("drain%0d.enq_ready", k), 32'(enq_ready), (k == 0) ? 32'd0 : 32'd1);
    end
    check("drain.empty", 32'(upd_valid), 32'd0);
    check("drain.drop_kept", 32'(drop_count), 32'd2);

    // Build occupancy 5 with a live bypass on index 0x50, then reset
    set_in(1'b0, 2'b11, 10'h050, 10'h050, 2'b11, 2'd1, 2'd1, 1'b0);
    tick();
    check("rd.a.occupancy", 32'(occupancy), 32'd2);
    check("rd.a.upd_ctr", 32'(upd_ctr), 32'd2);
    upd_ready = 1'b1;
    tick();
    check("rd.b.occupancy", 32'(occupancy), 32'd3);
    check("rd.b.upd_ctr", 32'(upd_ctr), 32'd3);
    tick();
    tick();
    check("rd.d.occupancy", 32'(occupancy), 32'd5);
    check("rd.d.upd_ctr", 32'(upd_ctr), 32'd3);

    set_in(1'b1, 2'b11, 10'h050, 10'h050, 2'b11, 2'd1, 2'd1, 1'b1);
    tick();
    check("rst.occupancy", 32'(occupancy), 32'd0);
    check("rst.upd_valid", 32'(upd_valid), 32'd0);
    check("rst.drop_count", 32'(drop_count), 32'd0);
    check("rst.enq_ready", 32'(enq_ready), 32'd1);

    set_in(1'b0, 2'b01, 10'h050, 10'h000, 2'b01, 2'd1, 2'd0, 1'b1);
    tick();
    check("post.upd_valid", 32'(upd_valid), 32'd1);
    check("post.occupancy", 32'(occupancy), 32'd1);
    check("post.upd_index", 32'(upd_index), 32'h050);
    check("post.upd_ctr", 32'(upd_ctr), 32'd2);

    set_in(1'b0, 2'b00, 10'h0, 10'h0, 2'b00, 2'd0, 2'd0, 1'b1);
    tick();
    check("post.drained", 32'(occupancy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
